data_sram_responder: RTL and testbench

Target-side responder for the CPU data SRAM port (`data_sram_we/addr/wdata` in, `data_sram_rdata` out). It replaces the bare RAM behind the multi-cycle core with a word RAM plus a small MMIO register page: LEDs, switches, a free-running timer and a scratch register. All reads are registered, with one-cycle latency, which matches the core's MEM→WB state spacing. Out-of-map and misaligned accesses are flagged on a sticky error output.

---
 rtl/data_sram_responder_if.sv | 22 ++
 rtl/data_sram_responder.sv | 115 +++++++++++
 tb/tb_data_sram_responder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/data_sram_responder_if.sv
// CPU data SRAM port: write strobe, byte address and write data from the core,
// registered read data back to the core.
interface data_sram_responder_if;
   logic        data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_we,
      output data_sram_addr,
      output data_sram_wdata,
      input  data_sram_rdata
   );

   modport slave (
      input  data_sram_we,
      input  data_sram_addr,
      input  data_sram_wdata,
      output data_sram_rdata
   );
endinterface

// File: rtl/data_sram_responder.sv
// Data SRAM responder: word RAM plus an MMIO page (LED, SWITCH, TIMER, SCRATCH).
// Every cycle is an access, and read data is registered with one-cycle latency.
// Misses and misaligned accesses are dropped and set a sticky bus_err.
// Optional feature macro: DATA_SRAM_RESP_TIMER_EN (free-running TIMER at 0x008).
module data_sram_responder #(
   parameter int unsigned ADDR_W    = 10,
   parameter logic [31:0] RAM_BASE  = 32'h1c00_0000,
   parameter logic [31:0] MMIO_BASE = 32'hbfaf_f000
) (
   input  logic                        clk,
   input  logic                        reset,
   data_sram_responder_if.slave        bus,
   input  logic [15:0]                 switch_in,
   output logic [15:0]                 led_out,
   output logic                        bus_err
);

   localparam int unsigned DEPTH   = 1 << ADDR_W;
   localparam int unsigned RAM_LSB = ADDR_W + 2;

   logic [31:0]       mem [DEPTH];

   logic [31:0]       rdata_q, rdata_d;
   logic [15:0]       led_q, led_d;
   logic [31:0]       scratch_q, scratch_d;
   logic              bus_err_q, bus_err_d;
   logic [15:0]       sw_meta_q, sw_sync_q;
`ifdef DATA_SRAM_RESP_TIMER_EN
   logic [31:0]       timer_q, timer_d;
`endif

   logic              ram_hit, mmio_hit, aligned;
   logic [ADDR_W-1:0] ram_idx;
   logic              ram_we_c;

   // Address decode, read mux and register next-state
   always_comb begin
      rdata_d   = 32'h0;
      led_d     = led_q;
      scratch_d = scratch_q;
      bus_err_d = bus_err_q;
      ram_we_c  = 1'b0;
`ifdef DATA_SRAM_RESP_TIMER_EN
      timer_d   = timer_q + 32'd1;
`endif

      ram_hit  = (bus.data_sram_addr[31:RAM_LSB] == RAM_BASE[31:RAM_LSB]);
      mmio_hit = (bus.data_sram_addr[31:12] == MMIO_BASE[31:12]);
      aligned  = (bus.data_sram_addr[1:0] == 2'b00);
      ram_idx  = bus.data_sram_addr[RAM_LSB-1:2];

      if (!((ram_hit || mmio_hit) && aligned)) begin
         bus_err_d = 1'b1;
      end else if (ram_hit) begin
         rdata_d  = mem[ram_idx];
         ram_we_c = bus.data_sram_we;
      end else begin
         case (bus.data_sram_addr[11:0])
            12'h000: begin
               rdata_d = 32'(led_q);
               if (bus.data_sram_we) led_d = bus.data_sram_wdata[15:0];
            end
            12'h004: rdata_d = 32'(sw_sync_q);
            12'h008: begin
`ifdef DATA_SRAM_RESP_TIMER_EN
               rdata_d = timer_q;
               if (bus.data_sram_we) timer_d = bus.data_sram_wdata;
`endif
            end
            12'h00c: begin
               rdata_d = scratch_q;
               if (bus.data_sram_we) scratch_d = bus.data_sram_wdata;
            end
            default: rdata_d = 32'h0;
         endcase
      end
   end

   // Register state; reset dominates any same-cycle write
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q   <= 32'h0;
         led_q     <= 16'h0;
         scratch_q <= 32'h0;
         bus_err_q <= 1'b0;
         sw_meta_q <= 16'h0;
         sw_sync_q <= 16'h0;
`ifdef DATA_SRAM_RESP_TIMER_EN
         timer_q   <= 32'h0;
`endif
      end else begin
         rdata_q   <= rdata_d;
         led_q     <= led_d;
         scratch_q <= scratch_d;
         bus_err_q <= bus_err_d;
         sw_meta_q <= switch_in;
         sw_sync_q <= sw_meta_q;
`ifdef DATA_SRAM_RESP_TIMER_EN
         timer_q   <= timer_d;
`endif
      end
   end

   // RAM write port; contents survive reset but a write under reset is dropped
   always_ff @(posedge clk) begin
      if (ram_we_c && !reset) begin
         mem[ram_idx] <= bus.data_sram_wdata;
      end
   end

   assign bus.data_sram_rdata = rdata_q;
   assign led_out             = led_q;
   assign bus_err             = bus_err_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder; expectations follow the
// DATA_SRAM_RESP_TIMER_EN setting of the build.
module tb_data_sram_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] switch_in;
   logic [15:0] led_out;
   logic        bus_err;

   int n_chk  = 0;
   int n_pass = 0;

   data_sram_responder_if bus ();

   data_sram_responder dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .switch_in (switch_in),
      .led_out   (led_out),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   // One access per cycle; returns just after the edge ending the cycle
   task automatic acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      bus.data_sram_we    = we;
      bus.data_sram_addr  = addr;
      bus.data_sram_wdata = wdata;
      @(posedge clk);
      #1;
      bus.data_sram_we    = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] t0, t1, t2;
      logic        seen;
`ifdef DATA_SRAM_RESP_TIMER_EN
      t0 = 32'hffff_fffe; t1 = 32'hffff_ffff; t2 = 32'h0;
`else
      t0 = 32'h0; t1 = 32'h0; t2 = 32'h0;
`endif
      reset     = 1'b1;
      switch_in = 16'h0;
      bus.data_sram_we    = 1'b0;
      bus.data_sram_addr  = 32'h1c00_0000;
      bus.data_sram_wdata = 32'h0;
      acc(1'b0, 32'h1c00_0000, 32'h0);
      acc(1'b0, 32'h1c00_0000, 32'h0);
      chk("reset_rdata", bus.data_sram_rdata, 32'h0);
      chk("reset_led", 32'(led_out), 32'h0);
      chk("reset_err", 32'(bus_err), 32'h0);
      reset = 1'b0;

      // RAM write then read
      acc(1'b1, 32'h1c00_0010, 32'hdead_beef);
      acc(1'b0, 32'h1c00_0010, 32'h0);
      chk("ram_rd", bus.data_sram_rdata, 32'hdead_beef);

      // Read-before-write
      acc(1'b1, 32'h1c00_0020, 32'h5);
      acc(1'b1, 32'h1c00_0020, 32'h1);
      chk("ram_rbw_old", bus.data_sram_rdata, 32'h5);
      acc(1'b0, 32'h1c00_0020, 32'h0);
      chk("ram_rbw_new", bus.data_sram_rdata, 32'h1);

      // LED
      acc(1'b1, 32'hbfaf_f000, 32'h0001_a5a5);
      chk("led_wr_old", bus.data_sram_rdata, 32'h0);
      chk("led_out", 32'(led_out), 32'h0000_a5a5);
      acc(1'b0, 32'hbfaf_f000, 32'h0);
      chk("led_rd", bus.data_sram_rdata, 32'h0000_a5a5);

      // Switches through the synchroniser, visible within 3 cycles
      switch_in = 16'h00ff;
      seen = 1'b0;
      for (int i = 0; i < 3 && !seen; i++) begin
         acc(1'b0, 32'hbfaf_f004, 32'h0);
         if (bus.data_sram_rdata === 32'h0000_00ff) seen = 1'b1;
      end
      chk("switch_rd", bus.data_sram_rdata, 32'h0000_00ff);
      acc(1'b1, 32'hbfaf_f004, 32'h1234_0000);
      acc(1'b0, 32'hbfaf_f004, 32'h0);
      chk("switch_ro", bus.data_sram_rdata, 32'h0000_00ff);

      // Scratch and an unmapped in-page offset
      acc(1'b1, 32'hbfaf_f00c, 32'h1234_5678);
      chk("scratch_old", bus.data_sram_rdata, 32'h0);
      acc(1'b0, 32'hbfaf_f00c, 32'h0);
      chk("scratch_rd", bus.data_sram_rdata, 32'h1234_5678);
      acc(1'b1, 32'hbfaf_f010, 32'hffff_ffff);
      acc(1'b0, 32'hbfaf_f010, 32'h0);
      chk("unmapped_rd", bus.data_sram_rdata, 32'h0);
      chk("unmapped_noerr", 32'(bus_err), 32'h0);

      // Timer load and wrap
      acc(1'b1, 32'hbfaf_f008, 32'hffff_fffe);
      acc(1'b0, 32'hbfaf_f008, 32'h0);
      chk("timer_0", bus.data_sram_rdata, t0);
      acc(1'b0, 32'hbfaf_f008, 32'h0);
      chk("timer_1", bus.data_sram_rdata, t1);
      acc(1'b0, 32'hbfaf_f008, 32'h0);
      chk("timer_wrap", bus.data_sram_rdata, t2);
      chk("timer_noerr", 32'(bus_err), 32'h0);

      // Miss and misaligned accesses
      acc(1'b0, 32'h0000_1000, 32'h0);
      chk("miss_rdata", bus.data_sram_rdata, 32'h0);
      chk("miss_err", 32'(bus_err), 32'h1);
      acc(1'b1, 32'h1c00_0012, 32'h0);
      chk("misal_rdata", bus.data_sram_rdata, 32'h0);
      acc(1'b1, 32'hbfaf_f001, 32'h0000_0000);
      acc(1'b0, 32'h1c00_0010, 32'h0);
      chk("misal_ram_drop", bus.data_sram_rdata, 32'hdead_beef);
      chk("misal_led_drop", 32'(led_out), 32'h0000_a5a5);
      chk("err_sticky", 32'(bus_err), 32'h1);

      // Reset suppresses a same-cycle write
      acc(1'b1, 32'h1c00_0030, 32'h1111_2222);
      reset = 1'b1;
      acc(1'b1, 32'h1c00_0030, 32'hcafe_f00d);
      reset = 1'b0;
      chk("rst_rdata", bus.data_sram_rdata, 32'h0);
      chk("rst_led", 32'(led_out), 32'h0);
      chk("rst_err", 32'(bus_err), 32'h0);
      acc(1'b0, 32'hbfaf_f008, 32'h0);
      chk("rst_timer", bus.data_sram_rdata, 32'h0);
      acc(1'b0, 32'hbfaf_f00c, 32'h0);
      chk("rst_scratch", bus.data_sram_rdata, 32'h0);
      acc(1'b0, 32'h1c00_0030, 32'h0);
      chk("rst_ram_kept", bus.data_sram_rdata, 32'h1111_2222);
      acc(1'b0, 32'h1c00_0010, 32'h0);
      chk("rst_ram_other", bus.data_sram_rdata, 32'hdead_beef);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
